run_monitor: RTL

//  Synthesizable run/halt monitor for the pipelined processor, one instance beside proc_top.

---
 rtl/run_monitor.sv | 102 ++++++++++
 1 files changed

// File: rtl/run_monitor.sv
// Run/halt monitor: watches the fetch PC for a halt sentinel, drains, then flags done or watchdog timeout.
// Optional macro RUN_MONITOR_STALL_STATS_EN enables the stall_count register (otherwise tied to 0).
module run_monitor #(
  parameter logic [31:0] HALT_PC      = 32'h80088008,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 1_000_000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [31:0]      next_pc,
  input  logic             pc_valid,
  input  logic             retire,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, TIMEOUT} state_t;

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD =
    (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;
  localparam bit WD_EN = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST =
    (MAX_CYCLES != 0) ? CNT_W'(MAX_CYCLES - 1) : '0;

  state_t        state_q, state_d;
  logic [DW-1:0] drain_cnt;
  logic          sentinel;
  logic          cnt_en;

  assign sentinel = pc_valid && (next_pc == HALT_PC);
  assign cnt_en   = (state_q == RUN) || (state_q == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Sentinel wins over the watchdog when both fire in the same RUN cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN: begin
        if (sentinel)
          state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        else if (WD_EN && (cycle_count == WD_LAST))
          state_d = TIMEOUT;
      end
      DRAIN:   if (drain_cnt == '0) state_d = DONE;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    running = (state_q == RUN) || (state_q == DRAIN);
    done    = (state_q == DONE);
    timeout = (state_q == TIMEOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if ((state_q == RUN) && sentinel) begin
      drain_cnt <= DRAIN_LOAD;
    end else if ((state_q == DRAIN) && (drain_cnt != '0)) begin
      drain_cnt <= drain_cnt - DW'(1);
    end
  end

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count  <= '0;
      retire_count <= '0;
    end else if (cnt_en) begin
      if (cycle_count != '1)
        cycle_count <= cycle_count + CNT_W'(1);
      if (retire && (retire_count != '1))
        retire_count <= retire_count + CNT_W'(1);
    end
  end

`ifdef RUN_MONITOR_STALL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if ((state_q == RUN) && !pc_valid && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule
